// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Multiply is shift-add into a 64-bit accumulator. Divide is restoring
// division, with the remainder in the upper half and the quotient in the lower half.
// Optional build macro FAST_SPECIAL_EN: divide-by-zero and signed overflow
// complete at the acceptance edge with 1-cycle latency. The default build runs
// them through the full 32-iteration path, which produces the same values.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            nRST,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, next_state;

  logic [2:0]        op;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              sign_a, sign_b;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;

  logic              load, last, fast_hit;
  logic              in_sign_a, in_sign_b;
  logic [XLEN-1:0]   in_abs_a, in_abs_b;
  logic [XLEN:0]     mul_sum, div_tmp, div_diff;
  logic [2*XLEN-1:0] acc_mul, acc_div, acc_next, prod;
  logic [XLEN-1:0]   quo, rem, quo_c, rem_c, final_res;

  assign load = (state == IDLE) && start && !abort;
  assign last = (state == BUSY) && !abort && (cnt == CNT_W'(XLEN-1));

  // Operand decode at acceptance: MULH/DIV/REM are signed on both sides, and MULHSU is signed on op_a only.
  always_comb begin
    in_sign_a = 1'b0;
    in_sign_b = 1'b0;
    case (funct3)
      3'd1, 3'd4, 3'd6: begin
        in_sign_a = op_a[XLEN-1];
        in_sign_b = op_b[XLEN-1];
      end
      3'd2:    in_sign_a = op_a[XLEN-1];
      default: ;
    endcase
    in_abs_a = in_sign_a ? -op_a : op_a;
    in_abs_b = in_sign_b ? -op_b : op_b;
  end

`ifdef FAST_SPECIAL_EN
  logic            div_zero_in, div_ovf_in;
  logic [XLEN-1:0] special_res;

  // Detect the early-out divide cases and their architectural results.
  always_comb begin
    div_zero_in = (op_b == '0);
    div_ovf_in  = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    fast_hit    = funct3[2] && (div_zero_in || div_ovf_in);
    if (div_zero_in)
      special_res = funct3[1] ? op_a : '1;
    else
      special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end
`else
  assign fast_hit = 1'b0;
`endif

  // One iteration step, followed by sign correction and result selection on the final step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, abs_a} : '0);
    acc_mul  = {mul_sum, acc[XLEN-1:1]};
    div_tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_tmp - {1'b0, abs_b};
    acc_div  = div_diff[XLEN] ? {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_next = op[2] ? acc_div : acc_mul;
    prod     = (sign_a ^ sign_b) ? -acc_next : acc_next;
    quo      = acc_next[XLEN-1:0];
    rem      = acc_next[2*XLEN-1:XLEN];
    quo_c    = (abs_b == '0) ? '1 : ((sign_a ^ sign_b) ? -quo : quo);
    rem_c    = sign_a ? -rem : rem;
    case (op)
      3'd0:             final_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: final_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       final_res = quo_c;
      default:          final_res = rem_c;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and status outputs. An abort always returns the unit to IDLE.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE: if (load) next_state = fast_hit ? DONE : BUSY;
      BUSY: begin
        if (abort)     next_state = IDLE;
        else if (last) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch operands at acceptance, iterate while BUSY, and capture the result on the last step.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      op     <= '0;
      abs_a  <= '0;
      abs_b  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
    end else if (load) begin
      op     <= funct3;
      abs_a  <= in_abs_a;
      abs_b  <= in_abs_b;
      sign_a <= in_sign_a;
      sign_b <= in_sign_b;
      cnt    <= '0;
      acc    <= funct3[2] ? {{XLEN{1'b0}}, in_abs_a} : {{XLEN{1'b0}}, in_abs_b};
`ifdef FAST_SPECIAL_EN
      if (fast_hit) result <= special_res;
`endif
    end else if (state == BUSY && !abort) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (last) result <= final_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written multi-cycle sequences for muldiv_unit.
module tb_muldiv_unit;

`ifdef FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk, nRST, start, abort, busy, done;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[23];

  muldiv_unit dut (
    .clk    (clk),
    .nRST   (nRST),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One request: drive at negedge, accept at E0, scramble inputs, then wait for done with a cycle bound.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input bit special, input string tag);
    int lat;
    int explat;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~f; op_a = 32'hA5A5A5A5; op_b = 32'h5A5A5A5A;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    explat = (special && FAST) ? 0 : 32;
    checkOutput({tag, "_res"}, result, exp);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(explat));
    @(posedge clk); #1;
    checkOutput({tag, "_idle"}, {30'b0, busy, done}, 32'h0);
  endtask

  // Count done pulses over n cycles; used wherever no completion is allowed.
  task automatic countDone(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int n;
    int first_idx, second_idx;
    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[3]  = '{3'd3, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 1'b0};
    vecs[4]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[5]  = '{3'd2, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[6]  = '{3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0};
    vecs[7]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[8]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[9]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[11] = '{3'd5, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[12] = '{3'd7, 32'd100,      32'd7,        32'd2,        1'b0};
    vecs[13] = '{3'd4, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0};
    vecs[14] = '{3'd6, 32'd20,       32'hFFFFFFFD, 32'd2,        1'b0};
    vecs[15] = '{3'd5, 32'd123,      32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[16] = '{3'd6, 32'd123,      32'd0,        32'd123,      1'b1};
    vecs[17] = '{3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[18] = '{3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1};
    vecs[19] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[20] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[21] = '{3'd7, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1};
    vecs[22] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};

    nRST = 1'b0; start = 1'b0; abort = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    #1;
    checkOutput("reset_state", {busy, done, 30'b0} | result, 32'h0);
    #11 nRST = 1'b1;

    for (int i = 0; i < 23; i++)
      applyStimulus(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].special,
                    $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of MUL 5*6.
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 nRST = 1'b0;
    #1;
    checkOutput("midreset_busy",   {31'b0, busy}, 32'h0);
    checkOutput("midreset_done",   {31'b0, done}, 32'h0);
    checkOutput("midreset_result", result,        32'h0);
    @(negedge clk) nRST = 1'b1;
    countDone(40, n);
    checkOutput("midreset_nodone", 32'(n), 32'h0);

    // Abort at iteration 10 of DIVU 1000/3, with a start held on the abort edge.
    applyStimulus(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, "pre_abort");
    @(negedge clk);
    funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    abort = 1'b1; start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    checkOutput("abort_busy",   {31'b0, busy}, 32'h0);
    checkOutput("abort_done",   {31'b0, done}, 32'h0);
    checkOutput("abort_result", result,        32'd14);
    countDone(40, n);
    checkOutput("abort_nodone", 32'(n), 32'h0);
    checkOutput("abort_result_hold", result, 32'd14);

    // abort together with start in IDLE: the request must not be accepted.
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("idle_abort_busy", {31'b0, busy}, 32'h0);
    countDone(40, n);
    checkOutput("idle_abort_nodone", 32'(n), 32'h0);

    // start held high: accepts at E0, E34, E68, with done after E32, E66, E100.
    @(negedge clk);
    funct3 = 3'd2; op_a = 32'hFFFFFFFF; op_b = 32'd2; start = 1'b1;
    n = 0; first_idx = -1; second_idx = -1;
    for (int i = 0; i < 110; i++) begin
      @(posedge clk); #1;
      if (i == 69) start = 1'b0;
      if (i == 33) checkOutput("cont_idle_e33", {31'b0, busy}, 32'h0);
      if (done) begin
        if (n == 0) first_idx = i;
        if (n == 1) second_idx = i;
        n++;
      end
    end
    checkOutput("cont_done_count", 32'(n), 32'd3);
    checkOutput("cont_first_done", 32'(first_idx), 32'd32);
    checkOutput("cont_second_done", 32'(second_idx), 32'd66);
    checkOutput("cont_result", result, 32'hFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
